// File: rtl/pipelined_barrel_shifter.sv
// Pipelined rotate/shift unit: stage k applies a 2^k shift when shamt bit k is set.
// Valid/ready on both sides; each stage advances when empty or when its successor advances.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam logic [1:0] OpRor = 2'b00;
  localparam logic [1:0] OpRol = 2'b01;
  localparam logic [1:0] OpSrl = 2'b10;

  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input int unsigned      stage);
    int unsigned      amt;
    logic [WIDTH-1:0] r;
    amt = 32'd1 << stage;
    case (op)
      OpRor:   r = (d >> amt) | (d << (WIDTH - amt));
      OpRol:   r = (d << amt) | (d >> (WIDTH - amt));
      OpSrl:   r = d >> amt;
      default: r = $unsigned($signed(d) >>> amt);
    endcase
    return r;
  endfunction

  logic [SHAMT_W-1:0] valid_q, valid_d, load, src_valid;
  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic [WIDTH-1:0]   data_d  [SHAMT_W];
  logic [WIDTH-1:0]   src_data[SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_d  [SHAMT_W];
  logic [SHAMT_W-1:0] src_shamt[SHAMT_W];
  logic [1:0]         op_q  [SHAMT_W];
  logic [1:0]         op_d  [SHAMT_W];
  logic [1:0]         src_op[SHAMT_W];
  logic               rdy_en_q;

  // Stage k may load unless it and every stage after it is full and the output is stalled.
  always_comb begin : advance
    logic all_full;
    all_full = 1'b1;
    load     = '0;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      all_full = all_full & valid_q[k];
      load[k]  = out_ready | ~all_full;
    end
  end

  assign in_ready = rdy_en_q & load[0];

  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid & in_ready;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op;
    for (int k = 1; k < SHAMT_W; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_op[k]    = op_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < SHAMT_W; k++) begin
      data_d[k]  = data_q[k];
      shamt_d[k] = shamt_q[k];
      op_d[k]    = op_q[k];
      if (load[k]) begin
        valid_d[k] = src_valid[k];
        data_d[k]  = src_shamt[k][k] ? shift_stage(src_data[k], src_op[k], k) : src_data[k];
        shamt_d[k] = src_shamt[k];
        op_d[k]    = src_op[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q <= 1'b0;
      valid_q  <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
      end
    end else begin
      rdy_en_q <= 1'b1;
      valid_q  <= valid_d;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        op_q[k]    <= op_d[k];
      end
    end
  end

  assign out_valid = valid_q[SHAMT_W-1];
  assign out_data  = data_q[SHAMT_W-1];

  // The last stage's shamt/op are carried for uniformity but have no consumer.
  logic unused_tail;
  assign unused_tail = ^{shamt_q[SHAMT_W-1], op_q[SHAMT_W-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=32): expected results queued at
// input transfer, popped and compared at output transfer.
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          cnt_in = 0;
  int          cnt_out = 0;
  bit          chk_lat = 1'b0;
  int          first_in = -1;
  int          last_in = -1;
  logic [31:0] drv_exp = '0;
  logic [31:0] exp_q[$];
  int          stamp_q[$];

  pipelined_barrel_shifter #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] sh,
                                        input logic [1:0] op);
    logic [63:0] dd;
    logic [63:0] t;
    dd = {d, d};
    case (op)
      2'b00: begin t = dd >> sh; return t[31:0]; end
      2'b01: begin t = dd << sh; return t[63:32]; end
      2'b10: return d >> sh;
      default: return $unsigned($signed(d) >>> sh);
    endcase
  endfunction

  task automatic monitor_loop();
    logic [31:0] e;
    int          s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_valid && in_ready) begin
          exp_q.push_back(drv_exp);
          stamp_q.push_back(cyc);
          cnt_in++;
          if (chk_lat) begin
            if (first_in < 0) first_in = cyc;
            last_in = cyc;
          end
        end
        if (out_valid && out_ready) begin
          cnt_out++;
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output got %h, required no output", out_data);
          end else begin
            e = exp_q.pop_front();
            s = stamp_q.pop_front();
            if (out_data !== e) begin
              miscompares++;
              $display("FAIL result got %h, required %h", out_data, e);
            end
            if (chk_lat) begin
              vectors++;
              if (cyc - s != 5) begin
                miscompares++;
                $display("FAIL latency got %0d, required 5", cyc - s);
              end
            end
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                      input logic [31:0] exp);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    drv_exp  = exp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 500);
    if (!in_ready) begin
      miscompares++;
      $display("FAIL send_timeout in_ready got %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout pending got %0d, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors += 3;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid got %b, required 0", out_valid);
    end
    if (out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out_data got %h, required 00000000", out_data);
    end
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready got %b, required 0", in_ready);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL release_in_ready got %b, required 0", in_ready);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL first_clock_in_ready got %b, required 1", in_ready);
    end
  endtask

  task automatic test_ror();
    logic [31:0] e;
    out_ready = 1'b1;
    for (int sh = 0; sh < 32; sh++) begin
      case (sh)
        0:       e = 32'h2F6A692D;
        1:       e = 32'h97B53496;
        8:       e = 32'h2D2F6A69;
        default: e = model(32'h2F6A692D, 5'(sh), 2'b00);
      endcase
      send(32'h2F6A692D, 5'(sh), 2'b00, e);
    end
    drain();
  endtask

  task automatic test_ops();
    send(32'h2F6A692D, 5'd4, 2'b01, 32'hF6A692D2);
    send(32'h80000000, 5'd31, 2'b10, 32'h00000001);
    send(32'h80000000, 5'd31, 2'b11, 32'hFFFFFFFF);
    send(32'h7FFFFFFF, 5'd4, 2'b11, 32'h07FFFFFF);
    send(32'hC0FFEE11, 5'd0, 2'b11, 32'hC0FFEE11);
    send(32'hC0FFEE11, 5'd0, 2'b01, 32'hC0FFEE11);
    send(32'h80000001, 5'd31, 2'b01, 32'hC0000000);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    out_ready = 1'b1;
    chk_lat   = 1'b1;
    first_in  = -1;
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      send(d, 5'(i), 2'(i % 4), model(d, 5'(i), 2'(i % 4)));
    end
    drain();
    chk_lat = 1'b0;
    vectors++;
    if (last_in - first_in != 31) begin
      miscompares++;
      $display("FAIL b2b_input_span got %0d, required 31", last_in - first_in);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    logic [31:0] d;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 32'h1000_0001 * (i + 3);
      send(d, 5'(i * 3), 2'(i % 4), model(d, 5'(i * 3), 2'(i % 4)));
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full_out_valid got %b, required 1", out_valid);
    end
    held = out_data;
    fork
      send(32'hDEADBEEF, 5'd7, 2'b00, model(32'hDEADBEEF, 5'd7, 2'b00));
      begin
        repeat (10) begin
          @(negedge clk);
          vectors += 2;
          if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_in_ready got %b, required 0", in_ready);
          end
          if (out_data !== held) begin
            miscompares++;
            $display("FAIL bp_hold got %h, required %h", out_data, held);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      send(d, 5'(31 - i), 2'b11, model(d, 5'(31 - i), 2'b11));
    end
    drain();
  endtask

  task automatic test_random();
    bit          done;
    logic [31:0] d;
    logic [4:0]  sh;
    logic [1:0]  op;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          d  = $urandom;
          sh = 5'($urandom_range(0, 31));
          op = 2'($urandom_range(0, 3));
          send(d, sh, op, model(d, sh, op));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    vectors++;
    if (cnt_in != cnt_out) begin
      miscompares++;
      $display("FAIL count_in_out got %0d out, required %0d", cnt_out, cnt_in);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(32'h11111111, 5'd1, 2'b00, 32'h88888888);
    send(32'h22222222, 5'd2, 2'b01, 32'h88888888);
    send(32'h33333333, 5'd3, 2'b10, 32'h06666666);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_out_valid got %b, required 1", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors += 2;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_out_valid got %b, required 0", out_valid);
    end
    if (out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL async_out_data got %h, required 00000000", out_data);
    end
    exp_q.delete();
    stamp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(32'hA5A5A5A5, 5'd4, 2'b00, 32'h5A5A5A5A);
    send(32'hF0000000, 5'd4, 2'b11, 32'hFF000000);
    drain();
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout reached at cycle %0d, required completion", cyc);
    $fatal(1);
  end

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_ror();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
